// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multicycle RV64I control path: opcodes, FSM states and select encodings.
// Also provides the per-opcode-class ALU operand/op-class selection.
package rv_ctrl_pkg;

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OcOp      = 4'd0,
    OcOpImm   = 4'd1,
    OcOp32    = 4'd2,
    OcOpImm32 = 4'd3,
    OcLoad    = 4'd4,
    OcStore   = 4'd5,
    OcBranch  = 4'd6,
    OcJal     = 4'd7,
    OcJalr    = 4'd8,
    OcLui     = 4'd9,
    OcAuipc   = 4'd10,
    OcIllegal = 4'd11
  } opc_class_t;

  typedef enum logic [1:0] {
    AluAdd   = 2'd0,
    AluFunct = 2'd1,
    AluCmp   = 2'd2,
    AluPassB = 2'd3
  } alu_class_t;

  typedef enum logic [1:0] {
    PcPlus4 = 2'd0,
    PcImm   = 2'd1,
    PcAlu   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbLoad = 2'd1,
    WbPc4  = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic       src_a;
    logic       src_b;
    alu_class_t cls;
  } alu_ctrl_t;

  // ALU setup is held from EXEC through MEM/WB so the combinational result stays valid.
  function automatic alu_ctrl_t alu_ctrl(input opc_class_t oc);
    alu_ctrl_t a;
    a = '{src_a: 1'b0, src_b: 1'b0, cls: AluAdd};
    case (oc)
      OcOp, OcOp32:       a.cls = AluFunct;
      OcOpImm, OcOpImm32: begin
        a.src_b = 1'b1;
        a.cls   = AluFunct;
      end
      OcLoad, OcStore,
      OcJalr:             a.src_b = 1'b1;
      OcBranch:           a.cls = AluCmp;
      OcLui: begin
        a.src_b = 1'b1;
        a.cls   = AluPassB;
      end
      OcAuipc: begin
        a.src_a = 1'b1;
        a.src_b = 1'b1;
      end
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rv_opc_decode.sv
// Opcode classifier: maps instr[6:0] onto the control path's opcode classes.
// Anything outside RV64I base opcodes is reported as OcIllegal.
module rv_opc_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opc_class_t opc_class_o
);

  always_comb begin
    opc_class_o = OcIllegal;
    case (opcode_i)
      OpcOp:      opc_class_o = OcOp;
      OpcOpImm:   opc_class_o = OcOpImm;
      OpcOp32:    opc_class_o = OcOp32;
      OpcOpImm32: opc_class_o = OcOpImm32;
      OpcLoad:    opc_class_o = OcLoad;
      OpcStore:   opc_class_o = OcStore;
      OpcBranch:  opc_class_o = OcBranch;
      OpcJal:     opc_class_o = OcJal;
      OpcJalr:    opc_class_o = OcJalr;
      OpcLui:     opc_class_o = OcLui;
      OpcAuipc:   opc_class_o = OcAuipc;
      default:    opc_class_o = OcIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV64I core (FETCH/DECODE/EXEC/MEM/WB) plus instret.
// Build option: define ILLEGAL_TRAP_EN to trap illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_class,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             mem_err,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  opc_class_t       opc_q, opc_d;
  opc_class_t       dec_class;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic             retire;
  logic             waiting;

  // Only the opcode field is consumed here; the rest belongs to the datapath decoders.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  rv_opc_decode u_opc_decode (
    .opcode_i    (instr[6:0]),
    .opc_class_o (dec_class)
  );

  // Next-state and retire logic.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        opc_d   = dec_class;
        state_d = StExec;
`ifdef ILLEGAL_TRAP_EN
        if (dec_class == OcIllegal) state_d = StTrap;
`endif
      end
      StExec: begin
        case (opc_q)
          OcLoad, OcStore: state_d = StMem;
          OcBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
          default:         state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (opc_q == OcStore) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output decode; everything is forced low while rst is asserted.
  pc_sel_t    pc_sel_c;
  wb_sel_t    wb_sel_c;
  alu_ctrl_t  alu_c;
  logic       mem_req_c;

  always_comb begin
    mem_req_c    = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_sel_c     = PcPlus4;
    alu_c        = '{src_a: 1'b0, src_b: 1'b0, cls: AluAdd};
    reg_write    = 1'b0;
    wb_sel_c     = WbAlu;
    trap         = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req_c    = 1'b1;
          mem_is_fetch = 1'b1;
          ir_write     = mem_ready;
        end
        StExec: begin
          alu_c = alu_ctrl(opc_q);
          case (opc_q)
            OcBranch: begin
              pc_write = 1'b1;
              pc_sel_c = br_taken ? PcImm : PcPlus4;
            end
            OcJal: begin
              pc_write = 1'b1;
              pc_sel_c = PcImm;
            end
            OcJalr: begin
              pc_write = 1'b1;
              pc_sel_c = PcAlu;
            end
            default: ;
          endcase
        end
        StMem: begin
          alu_c     = alu_ctrl(opc_q);
          mem_req_c = 1'b1;
          mem_we    = (opc_q == OcStore);
          // A store retires here, so it advances the PC on completion.
          pc_write  = (opc_q == OcStore) && mem_ready;
        end
        StWb: begin
          alu_c     = alu_ctrl(opc_q);
          reg_write = (opc_q != OcIllegal);
          pc_write  = (opc_q != OcJal) && (opc_q != OcJalr);
          case (opc_q)
            OcLoad:       wb_sel_c = WbLoad;
            OcJal, OcJalr: wb_sel_c = WbPc4;
            default:      wb_sel_c = WbAlu;
          endcase
        end
        StTrap: begin
`ifdef ILLEGAL_TRAP_EN
          trap = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = mem_req_c;
  assign pc_sel    = pc_sel_c;
  assign wb_sel    = wb_sel_c;
  assign alu_src_a = alu_c.src_a;
  assign alu_src_b = alu_c.src_b;
  assign alu_class = alu_c.cls;

  // Memory timeout: counts stalled request cycles; error is sticky and the FSM keeps waiting.
  assign waiting = mem_req_c & ~mem_ready;

  always_comb begin
    to_cnt_d  = '0;
    mem_err_d = mem_err_q;
    if ((MEM_TIMEOUT != 0) && waiting) begin
      to_cnt_d = to_cnt_q;
      if (!mem_err_q) begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (to_cnt_d == MEM_TIMEOUT) mem_err_d = 1'b1;
      end
    end
  end

  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      opc_q     <= OcIllegal;
      instret_q <= '0;
      mem_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      instret_q <= instret_d;
      mem_err_q <= mem_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign instret = rst ? '0 : instret_q;
  assign mem_err = rst ? 1'b0 : mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write;
  logic [1:0]  pc_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_class;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        mem_err, trap;
  logic [63:0] instret;

  multicycle_ctrl #(
    .CNT_W       (64),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_class    (alu_class),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .mem_err      (mem_err),
    .trap         (trap),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [14:0] ctl;
    logic        err;
    logic [63:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_instret;
  logic        exp_err;

  localparam logic [14:0] Z = 15'd0;

  // {req, we, fetch, ir_write, pc_write, pc_sel, src_a, src_b, class, reg_write, wb_sel, trap}
  function automatic logic [14:0] v(input logic req, we, fch, irw, pcw, input logic [1:0] pcs,
                                    input logic sa, sb, input logic [1:0] cl, input logic rw,
                                    input logic [1:0] wb, input logic tr);
    return {req, we, fch, irw, pcw, pcs, sa, sb, cl, rw, wb, tr};
  endfunction

  // Monitor: every cycle with a queued expectation is one comparison.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [14:0] act;
      e   = sb_q.pop_front();
      act = {mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_sel, alu_src_a, alu_src_b,
             alu_class, reg_write, wb_sel, trap};
      n_checks++;
      if (act === e.ctl && mem_err === e.err && instret === e.ir) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ctl=%b err=%b instret=%0d, want ctl=%b err=%b instret=%0d",
                 e.nm, act, mem_err, instret, e.ctl, e.err, e.ir);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic rdy, input logic bt,
                      input logic [14:0] ctl);
    exp_t e;
    rst       = r;
    mem_ready = rdy;
    br_taken  = bt;
    e.nm  = nm;
    e.ctl = ctl;
    e.err = r ? 1'b0 : exp_err;
    e.ir  = r ? 64'd0 : exp_instret;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      exp_instret = 64'd0;
      exp_err     = 1'b0;
    end
  endtask

  // Fetch (with optional stall cycles) followed by the DECODE cycle.
  task automatic fd(input string nm, input logic [31:0] i, input int waits);
    instr = i;
    for (int k = 0; k < waits; k++) step({nm, "_fwait"}, 1'b0, 1'b0, 1'b0, v(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0));
    step({nm, "_f"}, 1'b0, 1'b1, 1'b0, v(1,0,1,1,0,2'd0,0,0,2'd0,0,2'd0,0));
    step({nm, "_d"}, 1'b0, 1'b1, 1'b0, Z);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; instr = 32'h0;
    exp_instret = 64'd0; exp_err = 1'b0;

    step("reset0", 1'b1, 1'b0, 1'b0, Z);
    step("reset1", 1'b1, 1'b1, 1'b0, Z);

    // ADDI x1,x0,5
    fd("addi", 32'h00500093, 0);
    step("addi_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd1,0,2'd0,0));
    step("addi_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,1,2'd1,1,2'd0,0));
    exp_instret++;

    // LW x2,0(x1) with three MEM stall cycles
    fd("lw", 32'h0000A103, 0);
    step("lw_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0));
    for (int k = 0; k < 3; k++) step("lw_mwait", 0, 0, 0, v(1,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0));
    step("lw_m", 0, 1, 0, v(1,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0));
    step("lw_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,1,2'd0,1,2'd1,0));
    exp_instret++;

    // SW x2,4(x1)
    fd("sw", 32'h0020A223, 0);
    step("sw_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0));
    step("sw_m", 0, 1, 0, v(1,1,0,0,1,2'd0,0,1,2'd0,0,2'd0,0));
    exp_instret++;

    // BEQ +8 taken, then not taken
    fd("beq_t", 32'h00000463, 0);
    step("beq_t_e", 0, 1, 1, v(0,0,0,0,1,2'd1,0,0,2'd2,0,2'd0,0));
    exp_instret++;
    fd("beq_n", 32'h00000463, 0);
    step("beq_n_e", 0, 1, 0, v(0,0,0,0,1,2'd0,0,0,2'd2,0,2'd0,0));
    exp_instret++;

    // ADD x3,x1,x2 with two fetch stall cycles
    fd("add", 32'h002081B3, 2);
    step("add_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,0,2'd1,0,2'd0,0));
    step("add_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,0,2'd1,1,2'd0,0));
    exp_instret++;

    // LUI x1,0x12345
    fd("lui", 32'h123450B7, 0);
    step("lui_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd3,0,2'd0,0));
    step("lui_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,1,2'd3,1,2'd0,0));
    exp_instret++;

    // AUIPC x1,1
    fd("auipc", 32'h00001097, 0);
    step("auipc_e", 0, 1, 0, v(0,0,0,0,0,2'd0,1,1,2'd0,0,2'd0,0));
    step("auipc_w", 0, 1, 0, v(0,0,0,0,1,2'd0,1,1,2'd0,1,2'd0,0));
    exp_instret++;

    // JALR x1,0(x1)
    fd("jalr", 32'h000080E7, 0);
    step("jalr_e", 0, 1, 0, v(0,0,0,0,1,2'd2,0,1,2'd0,0,2'd0,0));
    step("jalr_w", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd0,1,2'd2,0));
    exp_instret++;

    // Illegal opcode 0x00000000
    fd("ill", 32'h00000000, 0);
`ifdef ILLEGAL_TRAP_EN
    step("ill_trap", 0, 1, 0, v(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,1));
`else
    step("ill_e", 0, 1, 0, Z);
    step("ill_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,0,2'd0,0,2'd0,0));
    exp_instret++;
`endif

    // JAL x1,16, then reset during the following FETCH
    fd("jal", 32'h010000EF, 0);
    step("jal_e", 0, 1, 0, v(0,0,0,0,1,2'd1,0,0,2'd0,0,2'd0,0));
    step("jal_w", 0, 1, 0, v(0,0,0,0,0,2'd0,0,0,2'd0,1,2'd2,0));
    exp_instret++;
    step("jal_rst", 1, 1, 0, Z);
    fd("lui2", 32'h123450B7, 0);
    step("lui2_e", 0, 1, 0, v(0,0,0,0,0,2'd0,0,1,2'd3,0,2'd0,0));
    step("lui2_w", 0, 1, 0, v(0,0,0,0,1,2'd0,0,1,2'd3,1,2'd0,0));
    exp_instret++;

    // Fetch timeout: mem_err after the fourth stalled cycle, sticky until reset
    instr = 32'h00500093;
    for (int k = 0; k < 4; k++) step("to_wait", 0, 0, 0, v(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0));
    exp_err = 1'b1;
    for (int k = 0; k < 2; k++) step("to_err", 0, 0, 0, v(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0));
    step("to_accept", 0, 1, 0, v(1,0,1,1,0,2'd0,0,0,2'd0,0,2'd0,0));
    step("to_dec", 0, 1, 0, Z);
    step("to_rst", 1, 0, 0, Z);
    step("to_after", 0, 0, 0, v(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0));

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multicycle RV64I core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the memory request handshake, IR/PC/regfile write enables, ALU operand and op-class selects, writeback and next-PC selects.
- The immediate generator decodes the latched IR combinationally; this block decides when its output is consumed (EXEC/MEM/WB).
- Also maintains a retired-instruction counter.

Parameters:
- CNT_W, 64, width of instret counter.
- MEM_TIMEOUT, 0, cycles before mem_err is flagged while waiting on mem_ready; 0 = never.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- instr  in  32  latched IR contents (valid from DECODE onward)
- mem_ready  in  1  memory accepts/completes the current request this cycle
- br_taken  in  1  ALU compare result for the current branch
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  store request
- mem_is_fetch  out  1  request is an instruction fetch (address = PC)
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared (JALR)
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_class  out  2  0 = ADD, 1 = FUNCT (funct3/funct7 decoded downstream), 2 = CMP, 3 = PASS_B
- reg_write  out  1  regfile write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- mem_err  out  1  sticky memory timeout flag
- trap  out  1  illegal-instruction trap pulse (feature only)
- instret  out  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP (TRAP exists only with the feature). State register plus an opcode-class register captured in DECODE from instr[6:0].
- Reset (synchronous, active-high, highest priority, also mid-operation): state = FETCH, instret = 0, mem_err = 0, timeout counter = 0, pending request abandoned. During the reset cycle every output is 0. The first request is issued in the cycle after rst deasserts.
- FETCH:
  - mem_req = 1, mem_is_fetch = 1.
  - Hold until mem_ready = 1. mem_req stays high, with attributes stable, until accepted.
  - On mem_ready: ir_write = 1, go to DECODE.
- DECODE:
  - One cycle. Regfile read and immediate settle.
  - Classify opcode: OP, OP-IMM, OP-32, OP-IMM-32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL. Go to EXEC.
- EXEC:
  - OP / OP-32: src_b = 0, class FUNCT → WB.
  - OP-IMM / OP-IMM-32: src_b = 1, class FUNCT → WB.
  - LOAD / STORE: src_b = 1, class ADD → MEM.
  - BRANCH: class CMP, src_b = 0. pc_write = 1 with pc_sel = 1 if br_taken, else pc_sel = 0. Instruction retires → FETCH.
  - JAL: pc_write, pc_sel = 1 → WB.
  - JALR: src_b = 1, class ADD, pc_write, pc_sel = 2 → WB.
  - LUI: src_b = 1, class PASS_B → WB.
  - AUIPC: src_a = 1, src_b = 1, class ADD → WB.
- MEM:
  - mem_req = 1; mem_we = 1 for STORE.
  - Hold until mem_ready. LOAD → WB. STORE retires → FETCH.
- WB:
  - reg_write = 1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - Non-jump instructions also assert pc_write with pc_sel = 0.
  - Retires → FETCH.
- Retire: instret increments by 1 in the cycle the instruction leaves its final state. It wraps modulo 2^CNT_W.
- Zero-wait latency (mem_ready high in the request cycle):
  - BRANCH: 3 cycles.
  - STORE, ALU ops, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
- Timeout: when MEM_TIMEOUT ≠ 0, a counter runs while mem_req = 1 and mem_ready = 0. Reaching MEM_TIMEOUT sets mem_err, which is sticky until rst. The FSM keeps waiting.
- rd = x0: reg_write is still asserted; the regfile ignores it.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: ILLEGAL opcode goes DECODE → TRAP. TRAP pulses trap = 1 for one cycle, does not retire, no PC or register write, then → FETCH. The PC is held; the trap handler redirects it externally.
- Undefined: ILLEGAL is treated as a NOP. It goes to WB with reg_write = 0 and pc_sel = 0, and retires. trap is tied to 0.

Decomposition:
- Shared package rv_ctrl_pkg:
  - opcode localparams (7-bit)
  - state_t enum
  - opc_class_t enum
  - alu_class_t, pc_sel_t, wb_sel_t enums
- Sub-module: none required. The opcode classifier rv_opc_decode (instr[6:0] → opc_class_t) is a natural combinational sub-module shared with the immediate generator's opcode set.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → states F,D,E,W. WB cycle: reg_write = 1, wb_sel = 0, src_b = 1. instret 0 → 1 after 4 cycles.
- LW x2,0(x1) (0x0000A103) with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles with mem_we = 0, then WB with wb_sel = 1. Total 8 cycles.
- SW x2,4(x1) (0x0020A223) → MEM asserts mem_we = 1. No reg_write at any point. Retires in 4 cycles.
- BEQ +8 (0x00000463): br_taken = 1 → EXEC pc_write = 1, pc_sel = 1. br_taken = 0 → pc_sel = 0. Both retire in 3 cycles.
- JAL x1,16 (0x010000EF) → EXEC pc_sel = 1. WB: reg_write = 1, wb_sel = 2. Then assert rst during the next FETCH → all outputs 0 that cycle, instret = 0, FETCH restarts the following cycle.
- Instr 0x00000000 → with ILLEGAL_TRAP_EN: one-cycle trap pulse, instret unchanged. Without: no writes, instret + 1. MEM_TIMEOUT = 4 with mem_ready held low → mem_err sets after 4 wait cycles and stays set.
